pipe_latch_idex: RTL and testbench

PIPE_LATCH_IDEX -- requirements
Module: pipe_latch_idex

---
 rtl/cpu_types_pkg.sv | 53 +++++
 rtl/pipe_reg_if.sv | 41 ++++
 rtl/pipe_bubble.sv | 13 +
 rtl/pipe_latch_idex.sv | 114 +++++++++++
 tb/tb_pipe_latch_idex.sv | 311 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_types_pkg.sv
// Shared CPU types: word and ALU op types, the ID/EX field bundle and the halt FSM states.
// The stage latches and the register interface all import these.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [3:0] {
        ALU_SLL,
        ALU_SRL,
        ALU_ADD,
        ALU_SUB,
        ALU_AND,
        ALU_OR,
        ALU_XOR,
        ALU_NOR,
        ALU_SLT,
        ALU_SLTU
    } aluop_t;

    typedef enum logic {
        RUN,
        HALTED
    } halt_state_t;

    // A bubble must decode as a harmless op, so SLL of zero is used.
    localparam aluop_t BUBBLE_ALUOP = ALU_SLL;

    typedef struct packed {
        logic       regDst;
        logic       branch;
        logic       WEN;
        logic       aluSrc;
        logic       jmp;
        logic       jl;
        logic       jmpReg;
        logic       memToReg;
        logic       dREN;
        logic       dWEN;
        logic       lui;
        logic       bne;
        logic       zeroExt;
        logic       shiftSel;
        logic [1:0] aluCont;
        aluop_t     aluOp;
        logic       halt;
        word_t      instr;
        word_t      incPC;
        word_t      pc;
        word_t      rdat1;
        word_t      rdat2;
    } idex_t;

endpackage

// File: rtl/pipe_reg_if.sv
// Field set carried between decode and execute.
// The rd modport is the latch input side; the wr modport is the latch output side.
interface pipe_reg_if;
    import cpu_types_pkg::*;

    logic       regDst;
    logic       branch;
    logic       WEN;
    logic       aluSrc;
    logic       jmp;
    logic       jl;
    logic       jmpReg;
    logic       memToReg;
    logic       dREN;
    logic       dWEN;
    logic       lui;
    logic       bne;
    logic       zeroExt;
    logic       shiftSel;
    logic [1:0] aluCont;
    aluop_t     aluOp;
    logic       halt;
    word_t      instr;
    word_t      incPC;
    word_t      pc;
    word_t      rdat1;
    word_t      rdat2;

    modport rd (
        input regDst, branch, WEN, aluSrc, jmp, jl, jmpReg, memToReg,
              dREN, dWEN, lui, bne, zeroExt, shiftSel, aluCont, aluOp,
              halt, instr, incPC, pc, rdat1, rdat2
    );

    modport wr (
        output regDst, branch, WEN, aluSrc, jmp, jl, jmpReg, memToReg,
               dREN, dWEN, lui, bne, zeroExt, shiftSel, aluCont, aluOp,
               halt, instr, incPC, pc, rdat1, rdat2
    );

endinterface

// File: rtl/pipe_bubble.sv
// Produces the zeroed ID/EX field set used for flushes, reset and halted drain.
module pipe_bubble
    import cpu_types_pkg::*;
(
    output idex_t bubble
);

    always_comb begin
        bubble       = '0;
        bubble.aluOp = BUBBLE_ALUOP;
    end

endmodule

// File: rtl/pipe_latch_idex.sv
// ID/EX pipeline latch with flush, stall, dhit request clearing and a sticky halt FSM.
// The same structure serves if_id, ex_mem and mem_wb with a different field bundle.
module pipe_latch_idex
    import cpu_types_pkg::*;
(
    input  logic       CLK,
    input  logic       nRST,
    pipe_reg_if.rd     prin,
    pipe_reg_if.wr     prout,
    input  logic       ihit,
    input  logic       dhit,
    input  logic       stall,
    input  logic       flush,
    output logic       halted
);

    idex_t       in_fields;
    idex_t       latched;
    idex_t       next_fields;
    idex_t       bubble;
    halt_state_t state;
    halt_state_t next_state;
    logic        adv;

    pipe_bubble u_bubble (
        .bubble (bubble)
    );

    assign adv = ihit & ~stall;

    always_comb begin
        in_fields.regDst   = prin.regDst;
        in_fields.branch   = prin.branch;
        in_fields.WEN      = prin.WEN;
        in_fields.aluSrc   = prin.aluSrc;
        in_fields.jmp      = prin.jmp;
        in_fields.jl       = prin.jl;
        in_fields.jmpReg   = prin.jmpReg;
        in_fields.memToReg = prin.memToReg;
        in_fields.dREN     = prin.dREN;
        in_fields.dWEN     = prin.dWEN;
        in_fields.lui      = prin.lui;
        in_fields.bne      = prin.bne;
        in_fields.zeroExt  = prin.zeroExt;
        in_fields.shiftSel = prin.shiftSel;
        in_fields.aluCont  = prin.aluCont;
        in_fields.aluOp    = prin.aluOp;
        in_fields.halt     = prin.halt;
        in_fields.instr    = prin.instr;
        in_fields.incPC    = prin.incPC;
        in_fields.pc       = prin.pc;
        in_fields.rdat1    = prin.rdat1;
        in_fields.rdat2    = prin.rdat2;
    end

    // A flushed entry never enters HALTED, but an existing halt survives the flush.
    always_comb begin
        next_fields = latched;
        next_state  = state;
        if (flush && adv) begin
            next_fields      = bubble;
            next_fields.halt = (state == HALTED);
        end else if (adv) begin
            if (state == HALTED) begin
                next_fields      = bubble;
                next_fields.halt = 1'b1;
            end else begin
                next_fields = in_fields;
                if (in_fields.halt) begin
                    next_state = HALTED;
                end
            end
        end else if (dhit) begin
            next_fields.dREN = 1'b0;
            next_fields.dWEN = 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            latched <= bubble;
            state   <= RUN;
        end else begin
            latched <= next_fields;
            state   <= next_state;
        end
    end

    assign halted = (state == HALTED);

    assign prout.regDst   = latched.regDst;
    assign prout.branch   = latched.branch;
    assign prout.WEN      = latched.WEN;
    assign prout.aluSrc   = latched.aluSrc;
    assign prout.jmp      = latched.jmp;
    assign prout.jl       = latched.jl;
    assign prout.jmpReg   = latched.jmpReg;
    assign prout.memToReg = latched.memToReg;
    assign prout.dREN     = latched.dREN;
    assign prout.dWEN     = latched.dWEN;
    assign prout.lui      = latched.lui;
    assign prout.bne      = latched.bne;
    assign prout.zeroExt  = latched.zeroExt;
    assign prout.shiftSel = latched.shiftSel;
    assign prout.aluCont  = latched.aluCont;
    assign prout.aluOp    = latched.aluOp;
    assign prout.halt     = latched.halt;
    assign prout.instr    = latched.instr;
    assign prout.incPC    = latched.incPC;
    assign prout.pc       = latched.pc;
    assign prout.rdat1    = latched.rdat1;
    assign prout.rdat2    = latched.rdat2;

endmodule

// File: tb/tb_pipe_latch_idex.sv
// Bench for pipe_latch_idex: directed scenarios then random traffic, with a reference
// model feeding an expected-value queue that a separate monitor drains every cycle.
module tb_pipe_latch_idex;
    import cpu_types_pkg::*;

    logic CLK;
    logic nRST;
    logic ihit;
    logic dhit;
    logic stall;
    logic flush;
    logic halted;

    int compared   = 0;
    int mismatched = 0;

    idex_t exp_fields_q[$];
    logic  exp_halted_q[$];

    pipe_reg_if prin_if ();
    pipe_reg_if prout_if ();

    pipe_latch_idex dut (
        .CLK    (CLK),
        .nRST   (nRST),
        .prin   (prin_if),
        .prout  (prout_if),
        .ihit   (ihit),
        .dhit   (dhit),
        .stall  (stall),
        .flush  (flush),
        .halted (halted)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    function automatic idex_t read_in();
        idex_t v;
        v.regDst   = prin_if.regDst;
        v.branch   = prin_if.branch;
        v.WEN      = prin_if.WEN;
        v.aluSrc   = prin_if.aluSrc;
        v.jmp      = prin_if.jmp;
        v.jl       = prin_if.jl;
        v.jmpReg   = prin_if.jmpReg;
        v.memToReg = prin_if.memToReg;
        v.dREN     = prin_if.dREN;
        v.dWEN     = prin_if.dWEN;
        v.lui      = prin_if.lui;
        v.bne      = prin_if.bne;
        v.zeroExt  = prin_if.zeroExt;
        v.shiftSel = prin_if.shiftSel;
        v.aluCont  = prin_if.aluCont;
        v.aluOp    = prin_if.aluOp;
        v.halt     = prin_if.halt;
        v.instr    = prin_if.instr;
        v.incPC    = prin_if.incPC;
        v.pc       = prin_if.pc;
        v.rdat1    = prin_if.rdat1;
        v.rdat2    = prin_if.rdat2;
        return v;
    endfunction

    function automatic idex_t read_out();
        idex_t v;
        v.regDst   = prout_if.regDst;
        v.branch   = prout_if.branch;
        v.WEN      = prout_if.WEN;
        v.aluSrc   = prout_if.aluSrc;
        v.jmp      = prout_if.jmp;
        v.jl       = prout_if.jl;
        v.jmpReg   = prout_if.jmpReg;
        v.memToReg = prout_if.memToReg;
        v.dREN     = prout_if.dREN;
        v.dWEN     = prout_if.dWEN;
        v.lui      = prout_if.lui;
        v.bne      = prout_if.bne;
        v.zeroExt  = prout_if.zeroExt;
        v.shiftSel = prout_if.shiftSel;
        v.aluCont  = prout_if.aluCont;
        v.aluOp    = prout_if.aluOp;
        v.halt     = prout_if.halt;
        v.instr    = prout_if.instr;
        v.incPC    = prout_if.incPC;
        v.pc       = prout_if.pc;
        v.rdat1    = prout_if.rdat1;
        v.rdat2    = prout_if.rdat2;
        return v;
    endfunction

    task automatic drive_in(input idex_t v);
        prin_if.regDst   = v.regDst;
        prin_if.branch   = v.branch;
        prin_if.WEN      = v.WEN;
        prin_if.aluSrc   = v.aluSrc;
        prin_if.jmp      = v.jmp;
        prin_if.jl       = v.jl;
        prin_if.jmpReg   = v.jmpReg;
        prin_if.memToReg = v.memToReg;
        prin_if.dREN     = v.dREN;
        prin_if.dWEN     = v.dWEN;
        prin_if.lui      = v.lui;
        prin_if.bne      = v.bne;
        prin_if.zeroExt  = v.zeroExt;
        prin_if.shiftSel = v.shiftSel;
        prin_if.aluCont  = v.aluCont;
        prin_if.aluOp    = v.aluOp;
        prin_if.halt     = v.halt;
        prin_if.instr    = v.instr;
        prin_if.incPC    = v.incPC;
        prin_if.pc       = v.pc;
        prin_if.rdat1    = v.rdat1;
        prin_if.rdat2    = v.rdat2;
    endtask

    function automatic idex_t random_fields(input logic with_halt);
        idex_t v;
        v = '0;
        {v.regDst, v.branch, v.WEN, v.aluSrc, v.jmp, v.jl, v.jmpReg,
         v.memToReg, v.dREN, v.dWEN, v.lui, v.bne, v.zeroExt, v.shiftSel} = 14'($urandom);
        v.aluCont = 2'($urandom);
        v.aluOp   = aluop_t'($urandom_range(0, 9));
        v.halt    = with_halt;
        v.instr   = $urandom;
        v.incPC   = $urandom;
        v.pc      = $urandom;
        v.rdat1   = $urandom;
        v.rdat2   = $urandom;
        return v;
    endfunction

    function automatic idex_t model_bubble(input logic halt_bit);
        idex_t v;
        v       = '0;
        v.aluOp = ALU_SLL;
        v.halt  = halt_bit;
        return v;
    endfunction

    // Reference model: what execute should see after each edge, from the stage rules.
    initial begin
        idex_t model_fields;
        logic  model_halted;
        model_fields = model_bubble(1'b0);
        model_halted = 1'b0;
        forever begin
            @(posedge CLK);
            if (!nRST) begin
                model_fields = model_bubble(1'b0);
                model_halted = 1'b0;
            end else if (flush && ihit && !stall) begin
                model_fields = model_bubble(model_halted);
            end else if (ihit && !stall) begin
                if (model_halted) begin
                    model_fields = model_bubble(1'b1);
                end else begin
                    model_fields = read_in();
                    if (model_fields.halt) model_halted = 1'b1;
                end
            end else if (dhit) begin
                model_fields.dREN = 1'b0;
                model_fields.dWEN = 1'b0;
            end
            exp_fields_q.push_back(model_fields);
            exp_halted_q.push_back(model_halted);
        end
    end

    initial begin
        idex_t got;
        idex_t want;
        logic  want_halted;
        forever begin
            @(posedge CLK);
            #1;
            compared++;
            if (exp_fields_q.size() == 0) begin
                mismatched++;
                $display("[TB] FAIL scoreboard_empty: no expected entry at %0t", $time);
            end else begin
                want        = exp_fields_q.pop_front();
                want_halted = exp_halted_q.pop_front();
                got         = read_out();
                if (got !== want) begin
                    mismatched++;
                    $display("[TB] FAIL prout_fields at %0t: got %h expected %h", $time, got, want);
                end
                compared++;
                if (halted !== want_halted) begin
                    mismatched++;
                    $display("[TB] FAIL halted_flag at %0t: got %b expected %b", $time, halted, want_halted);
                end
            end
        end
    end

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    task automatic apply_stimulus(input idex_t v, input logic ih, input logic st,
                                  input logic fl, input logic dh);
        @(negedge CLK);
        drive_in(v);
        ihit  = ih;
        stall = st;
        flush = fl;
        dhit  = dh;
        @(posedge CLK);
        #2;
    endtask

    // Reset asserted between edges must clear the latch before any clock edge.
    task automatic mid_cycle_reset(input string tag);
        @(negedge CLK);
        #2;
        nRST = 1'b0;
        #1;
        check_output({tag, "_instr"}, prout_if.instr, 32'h0);
        check_output({tag, "_pc"}, prout_if.pc, 32'h0);
        check_output({tag, "_rdat1"}, prout_if.rdat1, 32'h0);
        check_output({tag, "_aluop"}, 32'(prout_if.aluOp), 32'(ALU_SLL));
        check_output({tag, "_halt"}, 32'(prout_if.halt), 32'h0);
        check_output({tag, "_halted"}, 32'(halted), 32'h0);
        @(negedge CLK);
        nRST = 1'b1;
    endtask

    initial begin
        idex_t v;
        nRST  = 1'b0;
        ihit  = 1'b0;
        dhit  = 1'b0;
        stall = 1'b0;
        flush = 1'b0;
        drive_in('0);
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        nRST = 1'b1;

        v = random_fields(1'b0);
        apply_stimulus(v, 1'b1, 1'b0, 1'b0, 1'b0);
        mid_cycle_reset("reset");

        v       = random_fields(1'b0);
        v.instr = 32'h8C220004;
        v.dREN  = 1'b1;
        v.pc    = 32'h40;
        apply_stimulus(v, 1'b1, 1'b0, 1'b0, 1'b0);
        check_output("load_instr", prout_if.instr, 32'h8C220004);
        check_output("load_pc", prout_if.pc, 32'h40);
        check_output("load_dren", 32'(prout_if.dREN), 32'h1);

        apply_stimulus(random_fields(1'b0), 1'b1, 1'b1, 1'b0, 1'b1);
        check_output("stall_dhit_dren", 32'(prout_if.dREN), 32'h0);
        check_output("stall_dhit_dwen", 32'(prout_if.dWEN), 32'h0);
        check_output("stall_dhit_instr", prout_if.instr, 32'h8C220004);
        for (int i = 0; i < 3; i++) begin
            apply_stimulus(random_fields(1'b0), 1'b1, 1'b1, 1'b0, 1'b0);
            check_output("stall_hold_instr", prout_if.instr, 32'h8C220004);
            check_output("stall_hold_pc", prout_if.pc, 32'h40);
        end

        apply_stimulus(random_fields(1'b0), 1'b0, 1'b0, 1'b1, 1'b0);
        check_output("flush_no_ihit_instr", prout_if.instr, 32'h8C220004);
        apply_stimulus(random_fields(1'b0), 1'b1, 1'b0, 1'b1, 1'b0);
        check_output("flush_instr", prout_if.instr, 32'h0);
        check_output("flush_wen", 32'(prout_if.WEN), 32'h0);

        apply_stimulus(random_fields(1'b1), 1'b1, 1'b0, 1'b0, 1'b0);
        check_output("halt_enter", 32'(halted), 32'h1);
        v       = random_fields(1'b0);
        v.instr = 32'h20010001;
        apply_stimulus(v, 1'b1, 1'b0, 1'b0, 1'b0);
        check_output("halted_bubble_instr", prout_if.instr, 32'h0);
        check_output("halted_bubble_halt", 32'(prout_if.halt), 32'h1);
        apply_stimulus(random_fields(1'b0), 1'b1, 1'b0, 1'b1, 1'b0);
        check_output("halted_flush_sticky", 32'(halted), 32'h1);
        mid_cycle_reset("reset_halted");

        apply_stimulus(random_fields(1'b1), 1'b1, 1'b0, 1'b1, 1'b0);
        check_output("flushed_halt_halted", 32'(halted), 32'h0);
        check_output("flushed_halt_bit", 32'(prout_if.halt), 32'h0);

        for (int i = 0; i < 600; i++) begin
            @(negedge CLK);
            nRST  = (i % 80 != 79);
            drive_in(random_fields($urandom_range(0, 39) == 0));
            ihit  = ($urandom_range(0, 3) != 0);
            stall = ($urandom_range(0, 3) == 0);
            flush = ($urandom_range(0, 5) == 0);
            dhit  = ($urandom_range(0, 2) == 0);
        end
        @(negedge CLK);
        nRST = 1'b1;
        ihit = 1'b0;
        @(posedge CLK);
        #2;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
